// File: rtl/dcache_controller.sv
// dcache_controller
//   Sequencing FSM between the CPU load/store port, a direct-mapped write-back
//   data cache (2048 words, 3-bit tag, valid + dirty per line) and a
//   fixed-latency main memory. Hits complete in one lookup cycle. Misses write
//   back a dirty victim, refill the word from memory, then retry the lookup.
//
// Parameters
//   MEM_LATENCY : cycles memory address/data are held per access (1..15)
//
// Ports
//   clk, rst_b                : clock, asynchronous active-low reset
//   cpu_req/we/is_word        : CPU request, store flag, word/byte select
//   cpu_addr, cpu_wdata       : CPU byte address and store data
//   cpu_ready, cpu_done       : idle indicator, completion pulse
//   cpu_rdata                 : cache word of the last completed access
//   cache_addr/wdata/we/is_word/set_valid/set_dirty : cache control outputs
//   cache_hit/dirty/rdata/victim_addr               : cache status inputs
//   mem_addr/wdata/we, mem_rdata                    : main memory port
//   hit_count, miss_count     : first-lookup hit and miss statistics
module dcache_controller #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_is_word,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_wdata,
    output logic        cache_we,
    output logic        cache_is_word,
    output logic        cache_set_valid,
    output logic        cache_set_dirty,
    input  logic        cache_hit,
    input  logic        cache_dirty,
    input  logic [31:0] cache_rdata,
    input  logic [31:0] cache_victim_addr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, REFILL} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic        req_is_word;
    logic        retry;      // set once the first lookup has missed
    logic [3:0]  cnt;
    logic [31:0] fill_data;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_we      <= 1'b0;
            req_is_word <= 1'b0;
            retry       <= 1'b0;
            cnt         <= '0;
            fill_data   <= '0;
            cpu_rdata   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr    <= cpu_addr;
                        req_wdata   <= cpu_wdata;
                        req_we      <= cpu_we;
                        req_is_word <= cpu_is_word;
                        retry       <= 1'b0;
                        cnt         <= '0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        cpu_rdata <= cache_rdata;
                        if (!retry) hit_count <= hit_count + 32'd1;
                        state <= IDLE;
                    end else begin
                        if (!retry) miss_count <= miss_count + 32'd1;
                        retry <= 1'b1;
                        cnt   <= '0;
                        state <= cache_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= FILL;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FILL: begin
                    if (cnt == LAST_CNT) begin
                        cnt       <= '0;
                        fill_data <= mem_rdata;  // memory data is valid in the last hold cycle
                        state     <= REFILL;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                REFILL: state <= LOOKUP;
                default: state <= IDLE;
            endcase
        end
    end

    // The cache address tracks the registered request, including while idle.
    assign cache_addr = req_addr;

    always_comb begin
        cpu_ready       = (state == IDLE);
        cpu_done        = 1'b0;
        cache_we        = 1'b0;
        cache_is_word   = req_is_word;
        cache_wdata     = req_wdata;
        // Default write-back of the line's own status: a dirty line stays
        // valid and dirty; a clean tag-mismatched line may drop its valid bit.
        // Forced low while reset is asserted.
        cache_set_valid = rst_b & (cache_hit | cache_dirty);
        cache_set_dirty = rst_b & cache_dirty;
        mem_we          = 1'b0;
        mem_addr        = {req_addr[31:2], 2'b00};
        mem_wdata       = cache_rdata;
        case (state)
            LOOKUP: begin
                if (cache_hit) begin
                    cpu_done = 1'b1;
                    if (req_we) begin
                        cache_we        = 1'b1;
                        cache_set_valid = 1'b1;
                        cache_set_dirty = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                mem_we   = 1'b1;
                mem_addr = cache_victim_addr;
            end
            REFILL: begin
                cache_we        = 1'b1;
                cache_is_word   = 1'b1;
                cache_wdata     = fill_data;
                cache_set_valid = 1'b1;
                cache_set_dirty = 1'b0;
            end
            default: ;
        endcase
    end

    // After a refill the retried lookup must hit.
    retry_must_hit: assert property (@(posedge clk) disable iff (!rst_b)
        (state == LOOKUP && retry) |-> cache_hit);

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencing FSM between the CPU load/store port, the direct-mapped write-back data cache (2048 words, 3-bit tag, 1 valid + 1 dirty bit per line) and a fixed-latency main memory.
- On a hit, the controller finishes the access. On a miss, it writes back the victim line if it is dirty, refills the line from memory, then retries the lookup.
- The cache updates its valid and dirty bits on every clock, so this block owns set_valid, set_dirty and we_cache in every cycle.

Parameters:
- MEM_LATENCY, 4, cycles memory address/data must be held per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cpu_req  in  1  access request; sampled only while cpu_ready=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_is_word  in  1  1=word access, 0=byte access.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data; a byte store uses [7:0].
- cpu_ready  out  1  controller is idle and can accept a request.
- cpu_done  out  1  one-cycle pulse when the access completes.
- cpu_rdata  out  32  raw cache word of the completed access; held until the next cpu_done.
- cache_addr  out  32  address to the cache.
- cache_wdata  out  32  cache data_in.
- cache_we  out  1  cache we_cache.
- cache_is_word  out  1  cache is_word.
- cache_set_valid  out  1  cache set_valid.
- cache_set_dirty  out  1  cache set_dirty.
- cache_hit  in  1  cache hit flag.
- cache_dirty  in  1  cache dirty flag.
- cache_rdata  in  32  cache data_out packed, data_out[i] in bits [8i+7:8i].
- cache_victim_addr  in  32  cache memory_write_address.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  memory read data; valid in the last hold cycle.
- hit_count  out  32  completed accesses that hit on first lookup.
- miss_count  out  32  accesses that missed on first lookup.

Behaviour:
- States: IDLE, LOOKUP, WRITEBACK, FILL, REFILL.
- Reset (asynchronous, rst_b=0):
  - State goes to IDLE.
  - Request registers and cache_addr go to 0; cpu_rdata goes to 0; counters go to 0.
  - cpu_done, cache_we, mem_we, cache_set_valid and cache_set_dirty go to 0.
  - Cache contents are not touched. Reset mid-miss abandons the transfer; a partial memory write is permitted.
- cpu_ready=1 only in IDLE.
- Hold rule (every cycle not listed below):
  - cache_set_valid = cache_hit | cache_dirty.
  - cache_set_dirty = cache_dirty.
  - cache_we = 0.
  - A clean, tag-mismatched line may be invalidated; a dirty line is never lost.
- Addressing: cache_addr = registered request address in all states except IDLE, where it holds the last request address.
- IDLE: if cpu_req=1, register cpu_addr, cpu_we, cpu_is_word and cpu_wdata, then go to LOOKUP.
- LOOKUP, hit:
  - cpu_done=1 this cycle; cpu_rdata <= cache_rdata.
  - Store hit: cache_we=1, cache_is_word=req_is_word, cache_wdata=req_wdata, set_valid=1, set_dirty=1.
  - Load hit: hold rule.
  - Next state IDLE.
  - hit_count increments only if this is the first lookup of the request.
- LOOKUP, miss:
  - miss_count increments on the first lookup only.
  - Next state is WRITEBACK if cache_dirty=1, otherwise FILL.
  - A second miss on the retry lookup is a design error; flag it with an assertion.
- WRITEBACK, held MEM_LATENCY cycles by a 4-bit counter:
  - mem_we=1, mem_addr=cache_victim_addr, mem_wdata=cache_rdata.
  - When the counter reaches MEM_LATENCY-1, go to FILL with the counter cleared.
- FILL, MEM_LATENCY cycles:
  - mem_we=0, mem_addr={req_addr[31:2],2'b00}.
  - On the last cycle, latch mem_rdata into the fill register and go to REFILL.
- REFILL, 1 cycle:
  - cache_we=1, cache_is_word=1, cache_wdata=fill register, set_valid=1, set_dirty=0.
  - Next state LOOKUP (retry).
- mem_we is 0 outside WRITEBACK.
- Latency from the request-accept edge to cpu_done:
  - Hit: 1 cycle.
  - Clean miss: MEM_LATENCY+3 cycles.
  - Dirty miss: 2*MEM_LATENCY+3 cycles.
- Counters wrap modulo 2^32.
- cpu_req while not ready is ignored; the CPU must hold it until accepted.
- A byte store on a miss fills the word first, then merges the byte on the retry hit.

Test Plan:
- Reset, then load 0x0000_0040 on a cold cache -> miss, FILL at mem_addr 0x40 for 4 cycles, REFILL, cpu_done 7 cycles after accept with rdata=mem word; miss_count=1.
- Repeat the load of 0x40 -> cpu_done 1 cycle after accept, no memory activity; hit_count=1.
- Word store 0xDEADBEEF to 0x40, then load 0x2040 (same index, tag 1) -> WRITEBACK mem_we=1 at addr 0x40 with data 0xDEADBEEF for 4 cycles, then FILL from 0x2040; done after 11 cycles.
- Byte store 0xAB to 0x81 on a cold line -> fill from 0x80, retry hit writes the byte, line dirty=1; subsequent load returns the merged word.
- rst_b pulsed low during FILL -> outputs zero immediately (asynchronous); cpu_ready=1 after release; the next access to the same address misses cleanly.
- MEM_LATENCY=1 build: clean miss done in 4 cycles, dirty miss in 5.
